load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit for the pipelined MIPS core. It validates each access against alignment and the address map, raising AdEL/AdES in the same cycle. Valid accesses go out over a req/ack bus handshake with byte-lane stores and sign/zero-extended loads. While an access is in flight it stalls the pipeline, and a bounded timeout turns a hung bus into an address exception.

## Interface
Parameters:
- TIMEOUT, 16: cycles in REQ without `m_ack` before the access aborts; ≥1
- DM_END, 32'h0000_2fff: last valid data-memory byte address; DM spans 0..DM_END
- TIMER0_BASE, 32'h0000_7f00: timer 0 base; 12-byte window
- TIMER1_BASE, 32'h0000_7f10: timer 1 base; 12-byte window
- INTR_BASE, 32'h0000_7f20: interrupt-generator base; 4-byte window

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  M stage holds a memory instruction
- mem_op  in  4  0 none, 1 lw, 2 lh, 3 lb, 4 sw, 5 sh, 6 sb, 7 lhu, 8 lbu
- addr  in  32  effective byte address
- wdata  in  32  store data (rt)
- exc_ov  in  1  address adder overflowed
- flush  in  1  exception/eret kill of the M-stage instruction
- stall  out  1  freeze F..M stages
- m_req  out  1  bus request
- m_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- m_we  out  1  store
- m_byteen  out  4  byte-lane enables
- m_wdata  out  32  lane-replicated store data
- m_ack  in  1  bus completes request this cycle
- m_rdata  in  32  read word, valid with `m_ack`
- rdata  out  32  extended load result
- rdata_valid  out  1  `rdata` is valid for the W-stage register
- exc_adel  out  1  load address exception
- exc_ades  out  1  store address exception

## Operation
- Address check (combinational, IDLE only):
  - misaligned: word op with addr[1:0]≠0, half op with addr[0]=1
  - unmapped: outside DM, TIMER0..+0xb, TIMER1..+0xb, INTR..+0x3
  - timer window accessed by a non-word op
  - store to timer offset 8 (count register)
  - `exc_ov` set on any op
  - Any hit raises `exc_adel` (loads) or `exc_ades` (stores). No bus request, no stall.
- Store lanes:
  - sw: 4'b1111
  - sh: addr[1] ? 4'b1100 : 4'b0011, m_wdata={2{wdata[15:0]}}
  - sb: 4'b0001<<addr[1:0], m_wdata={4{wdata[7:0]}}
- Load extraction: the lane is selected by the latched addr[1:0]. lh/lb sign-extend; lhu/lbu zero-extend.
- FSM states:
  - IDLE: on `req_valid`, op≠0, no error and no `flush`, latch op/addr/wdata and go to REQ.
  - REQ: `m_req`=1 with stable address, write enable, byte enables and data.
    - `m_ack` → RESP, capturing `m_rdata`.
    - Timeout counter reaching TIMEOUT−1 → ERR.
  - RESP: `rdata_valid`=1 for loads only; then IDLE.
  - ERR: one-cycle `exc_adel`/`exc_ades` pulse per latched op; then IDLE.
- `stall` = (IDLE & accepting) | REQ. It is low in RESP/ERR, so the instruction retires or traps at the end of that cycle.
- `req_valid` is sampled only in IDLE, so the same instruction is never re-issued.
- `flush` in REQ: go to IDLE, drop `m_req`, no `rdata_valid`. This holds even if `m_ack` arrives in the same cycle; a store that is acked still completes on the bus.
- `flush` in IDLE suppresses both acceptance and exceptions.

## Timing
- Reset values: state IDLE, counter 0; `m_req`, `stall`, `rdata_valid`, `exc_adel`, `exc_ades` all 0; `rdata` 0; `m_addr`, `m_wdata`, `m_byteen` 0.
- Reset mid-access aborts immediately, with no exception.
- Acceptance at cycle T:
  - `m_req` is high from T+1.
  - The earliest ack is at T+1, giving `rdata_valid` at T+2 (minimum 2-cycle latency, 2 stall cycles).
- Timeout: TIMEOUT cycles of REQ are followed by ERR.
- Address-error exceptions are same-cycle combinational outputs; ERR exceptions are registered.
- Only one access is ever outstanding.

## Configuration
- `LSU_UNSIGNED_LOAD_EN` defined: mem_op 7 (lhu) and 8 (lbu) are legal, with half/byte alignment rules and zero-extension.
- Undefined: ops 7, 8 and 9–15 are treated as op 0, with no request, stall or exception.
- Ops 9–15 are always treated as op 0.

## Structure
- `lsu_pkg`: mem_op codes, FSM state enum, region sizes (12, 12, 4), timer count offset 8.
- Sub-module `lsu_addr_check`: combinational alignment/region/timer rules. Outputs are load-error and store-error.

## Test plan
- lw 0x0000_0010, `m_ack` 3 cycles after `m_req`, m_rdata 0x8081_8283 → rdata 0x8081_8283, stall high 4 cycles.
- lb addr 0x13, m_rdata 0x80FF_0000 → rdata 0xFFFF_FF80. With the macro defined, lbu → 0x0000_0080.
- sh addr 0x22, wdata 0x1234_ABCD → m_byteen 4'b1100, m_wdata 0xABCD_ABCD, m_we 1.
- lh 0x7f00 → exc_adel same cycle, no m_req. sw 0x7f08 → exc_ades. lw 0x3000 → exc_adel.
- lw with m_ack never asserted, TIMEOUT=4 → exc_adel pulse 5 cycles after acceptance, m_req drops.
- flush in the second REQ cycle → m_req 0 next cycle, no rdata_valid, FSM IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - mem_op codes, FSM state enum, access-size enum
//   - decoded-op record and decode_op() helper
//   - MMIO window sizes and the timer count-register offset
// Optional feature macro: LSU_UNSIGNED_LOAD_EN (enables lhu/lbu decode).
package lsu_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LW   = 4'd1,
        OP_LH   = 4'd2,
        OP_LB   = 4'd3,
        OP_SW   = 4'd4,
        OP_SH   = 4'd5,
        OP_SB   = 4'd6,
        OP_LHU  = 4'd7,
        OP_LBU  = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_ERR
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    typedef struct packed {
        logic  legal;
        logic  store;
        logic  sext;
        size_e size;
    } op_info_t;

    localparam logic [31:0] TIMER_WIN       = 32'd12;
    localparam logic [31:0] INTR_WIN        = 32'd4;
    localparam logic [31:0] TIMER_COUNT_OFS = 32'd8;

    // Illegal / unsupported codes decode to a non-legal record, which the
    // rest of the unit treats exactly like OP_NONE.
    function automatic op_info_t decode_op(input logic [3:0] op);
        op_info_t d;
        d = '{legal: 1'b0, store: 1'b0, sext: 1'b0, size: SZ_WORD};
        case (op)
            OP_LW:  d = '{legal: 1'b1, store: 1'b0, sext: 1'b0, size: SZ_WORD};
            OP_LH:  d = '{legal: 1'b1, store: 1'b0, sext: 1'b1, size: SZ_HALF};
            OP_LB:  d = '{legal: 1'b1, store: 1'b0, sext: 1'b1, size: SZ_BYTE};
            OP_SW:  d = '{legal: 1'b1, store: 1'b1, sext: 1'b0, size: SZ_WORD};
            OP_SH:  d = '{legal: 1'b1, store: 1'b1, sext: 1'b0, size: SZ_HALF};
            OP_SB:  d = '{legal: 1'b1, store: 1'b1, sext: 1'b0, size: SZ_BYTE};
`ifdef LSU_UNSIGNED_LOAD_EN
            OP_LHU: d = '{legal: 1'b1, store: 1'b0, sext: 1'b0, size: SZ_HALF};
            OP_LBU: d = '{legal: 1'b1, store: 1'b0, sext: 1'b0, size: SZ_BYTE};
`endif
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/load_store_unit_addr_check.sv
// lsu_addr_check: combinational address validation for one memory op.
// Ports:
//   op        in  4   raw mem_op code
//   addr      in  32  effective byte address
//   ovf       in  1   address adder overflow
//   load_err  out 1   load would raise AdEL
//   store_err out 1   store would raise AdES
// Optional feature macro: LSU_UNSIGNED_LOAD_EN (via lsu_pkg::decode_op).
module lsu_addr_check
    import lsu_pkg::*;
#(
    parameter logic [31:0] DM_END      = 32'h0000_2fff,
    parameter logic [31:0] TIMER0_BASE = 32'h0000_7f00,
    parameter logic [31:0] TIMER1_BASE = 32'h0000_7f10,
    parameter logic [31:0] INTR_BASE   = 32'h0000_7f20
) (
    input  logic [3:0]  op,
    input  logic [31:0] addr,
    input  logic        ovf,
    output logic        load_err,
    output logic        store_err
);

    op_info_t    d;
    logic [31:0] t0_ofs;
    logic [31:0] t1_ofs;
    logic [31:0] in_ofs;
    logic        in_dm, in_t0, in_t1, in_intr, in_timer;
    logic        misaligned, unmapped, timer_bad, err;

    always_comb begin
        d      = decode_op(op);
        t0_ofs = addr - TIMER0_BASE;
        t1_ofs = addr - TIMER1_BASE;
        in_ofs = addr - INTR_BASE;

        // Lower-bound compare first so the offset subtraction cannot wrap.
        in_dm    = (addr <= DM_END);
        in_t0    = (addr >= TIMER0_BASE) && (t0_ofs < TIMER_WIN);
        in_t1    = (addr >= TIMER1_BASE) && (t1_ofs < TIMER_WIN);
        in_intr  = (addr >= INTR_BASE)   && (in_ofs < INTR_WIN);
        in_timer = in_t0 || in_t1;

        misaligned = ((d.size == SZ_WORD) && (addr[1:0] != 2'b00))
                  || ((d.size == SZ_HALF) && addr[0]);
        unmapped   = !(in_dm || in_timer || in_intr);
        // Timers are word-only; the count register is read-only.
        timer_bad  = (in_timer && (d.size != SZ_WORD))
                  || (d.store && ((in_t0 && (t0_ofs == TIMER_COUNT_OFS))
                               || (in_t1 && (t1_ofs == TIMER_COUNT_OFS))));

        err       = d.legal && (ovf || misaligned || unmapped || timer_bad);
        load_err  = err && !d.store;
        store_err = err && d.store;
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage LSU with req/ack bus, stall and timeout.
// Ports:
//   clk, reset (sync, active-high)
//   req_valid, mem_op, addr, wdata, exc_ov, flush   : M-stage request side
//   stall                                           : freeze F..M
//   m_req, m_addr, m_we, m_byteen, m_wdata, m_ack, m_rdata : bus
//   rdata, rdata_valid                              : extended load result
//   exc_adel, exc_ades                              : address exceptions
// Optional feature macro: LSU_UNSIGNED_LOAD_EN (lhu/lbu support).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT     = 16,
    parameter logic [31:0] DM_END      = 32'h0000_2fff,
    parameter logic [31:0] TIMER0_BASE = 32'h0000_7f00,
    parameter logic [31:0] TIMER1_BASE = 32'h0000_7f10,
    parameter logic [31:0] INTR_BASE   = 32'h0000_7f20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        exc_ov,
    input  logic        flush,
    output logic        stall,
    output logic        m_req,
    output logic [31:0] m_addr,
    output logic        m_we,
    output logic [3:0]  m_byteen,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        exc_adel,
    output logic        exc_ades
);

    state_e      state, state_next;
    op_info_t    d;
    logic        store_q, sext_q;
    size_e       size_q;
    logic [1:0]  lane_q;
    logic [31:0] cnt;
    logic        load_err, store_err;
    logic        issue, accept, timed_out;
    logic [3:0]  lanes;
    logic [31:0] wdata_rep;
    logic [15:0] lane_h;
    logic [7:0]  lane_b;
    logic [31:0] load_ext;

    lsu_addr_check #(
        .DM_END      (DM_END),
        .TIMER0_BASE (TIMER0_BASE),
        .TIMER1_BASE (TIMER1_BASE),
        .INTR_BASE   (INTR_BASE)
    ) u_check (
        .op        (mem_op),
        .addr      (addr),
        .ovf       (exc_ov),
        .load_err  (load_err),
        .store_err (store_err)
    );

    always_comb begin
        d         = decode_op(mem_op);
        issue     = (state == S_IDLE) && req_valid && d.legal && !flush;
        accept    = issue && !load_err && !store_err;
        timed_out = (cnt == TIMEOUT - 1);

        case (d.size)
            SZ_HALF: begin
                lanes     = addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            SZ_BYTE: begin
                lanes     = 4'b0001 << addr[1:0];
                wdata_rep = {4{wdata[7:0]}};
            end
            default: begin
                lanes     = 4'b1111;
                wdata_rep = wdata;
            end
        endcase

        lane_h = lane_q[1] ? m_rdata[31:16] : m_rdata[15:0];
        case (lane_q)
            2'd1:    lane_b = m_rdata[15:8];
            2'd2:    lane_b = m_rdata[23:16];
            2'd3:    lane_b = m_rdata[31:24];
            default: lane_b = m_rdata[7:0];
        endcase
        case (size_q)
            SZ_HALF: load_ext = {{16{sext_q & lane_h[15]}}, lane_h};
            SZ_BYTE: load_ext = {{24{sext_q & lane_b[7]}}, lane_b};
            default: load_ext = m_rdata;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept) state_next = S_REQ;
            // flush wins over a same-cycle ack: the instruction is dead.
            S_REQ: begin
                if (flush)          state_next = S_IDLE;
                else if (m_ack)     state_next = S_RESP;
                else if (timed_out) state_next = S_ERR;
            end
            S_RESP:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        stall       = accept || (state == S_REQ);
        m_req       = (state == S_REQ);
        m_we        = (state == S_REQ) && store_q;
        rdata_valid = (state == S_RESP) && !store_q;
        exc_adel    = (issue && load_err)  || ((state == S_ERR) && !store_q);
        exc_ades    = (issue && store_err) || ((state == S_ERR) && store_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            store_q  <= 1'b0;
            sext_q   <= 1'b0;
            size_q   <= SZ_WORD;
            lane_q   <= '0;
            m_addr   <= '0;
            m_byteen <= '0;
            m_wdata  <= '0;
            rdata    <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                store_q  <= d.store;
                sext_q   <= d.sext;
                size_q   <= d.size;
                lane_q   <= addr[1:0];
                m_addr   <= {addr[31:2], 2'b00};
                m_byteen <= lanes;
                m_wdata  <= wdata_rep;
                cnt      <= '0;
            end else if (state == S_REQ) begin
                cnt <= cnt + 32'd1;
            end
            if ((state == S_REQ) && m_ack && !flush) begin
                rdata <= load_ext;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [3:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exc_ov;
    logic        flush;
    logic        stall;
    logic        m_req;
    logic [31:0] m_addr;
    logic        m_we;
    logic [3:0]  m_byteen;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        exc_adel;
    logic        exc_ades;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .mem_op(mem_op),
        .addr(addr), .wdata(wdata), .exc_ov(exc_ov), .flush(flush),
        .stall(stall), .m_req(m_req), .m_addr(m_addr), .m_we(m_we),
        .m_byteen(m_byteen), .m_wdata(m_wdata), .m_ack(m_ack),
        .m_rdata(m_rdata), .rdata(rdata), .rdata_valid(rdata_valid),
        .exc_adel(exc_adel), .exc_ades(exc_ades)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = 1'b0; mem_op = 4'd0; addr = '0; wdata = '0;
        exc_ov = 1'b0; flush = 1'b0; m_ack = 1'b0; m_rdata = '0;
    endtask

    // Issues one load, acks in REQ cycle ack_at, runs through RESP.
    task automatic run_load(input logic [3:0] op, input logic [31:0] a,
                            input int ack_at, input logic [31:0] rd,
                            output int stall_n, output int req_n,
                            output logic valid_seen, output logic [31:0] rd_seen);
        stall_n = 0; req_n = 0; valid_seen = 1'b0; rd_seen = '0;
        req_valid = 1'b1; mem_op = op; addr = a;
        #1;
        if (stall) stall_n++;
        tick();
        req_valid = 1'b0; mem_op = 4'd0;
        for (int c = 1; c <= ack_at + 1; c++) begin
            if (m_req) req_n++;
            m_ack   = (c == ack_at);
            m_rdata = (c == ack_at) ? rd : 32'h0;
            #1;
            if (stall) stall_n++;
            if (rdata_valid) begin
                valid_seen = 1'b1;
                rd_seen    = rdata;
            end
            tick();
            m_ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        tick(); tick();
        checks++; if (stall !== 1'b0)       begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (m_req !== 1'b0)       begin errors++; $display("FAIL reset_m_req: got %b want 0", m_req); end
        checks++; if (m_we !== 1'b0)        begin errors++; $display("FAIL reset_m_we: got %b want 0", m_we); end
        checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL reset_rdata_valid: got %b want 0", rdata_valid); end
        checks++; if ({exc_adel, exc_ades} !== 2'b00) begin errors++; $display("FAIL reset_exc: got %b want 00", {exc_adel, exc_ades}); end
        checks++; if (rdata !== 32'h0)      begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        checks++; if (m_addr !== 32'h0)     begin errors++; $display("FAIL reset_m_addr: got %h want 0", m_addr); end
        checks++; if (m_wdata !== 32'h0)    begin errors++; $display("FAIL reset_m_wdata: got %h want 0", m_wdata); end
        checks++; if (m_byteen !== 4'h0)    begin errors++; $display("FAIL reset_m_byteen: got %b want 0000", m_byteen); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_lw();
        int sn, rn; logic v; logic [31:0] r;
        run_load(4'd1, 32'h0000_0010, 3, 32'h8081_8283, sn, rn, v, r);
        checks++; if (sn !== 4) begin errors++; $display("FAIL lw_stall_cycles: got %0d want 4", sn); end
        checks++; if (rn !== 3) begin errors++; $display("FAIL lw_req_cycles: got %0d want 3", rn); end
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL lw_rdata_valid: got %b want 1", v); end
        checks++; if (r !== 32'h8081_8283) begin errors++; $display("FAIL lw_rdata: got %h want 80818283", r); end
    endtask

    task automatic test_loads();
        int sn, rn; logic v; logic [31:0] r;
        logic [3:0]  ops [4] = '{4'd3, 4'd2, 4'd2, 4'd3};
        logic [31:0] adr [4] = '{32'h13, 32'h12, 32'h10, 32'h11};
        logic [31:0] rdw [4] = '{32'h80FF_0000, 32'h80FF_0000, 32'h1234_8001, 32'h0000_7F00};
        logic [31:0] exp [4] = '{32'hFFFF_FF80, 32'hFFFF_80FF, 32'hFFFF_8001, 32'h0000_007F};
        for (int i = 0; i < 4; i++) begin
            run_load(ops[i], adr[i], 1, rdw[i], sn, rn, v, r);
            checks++; if (sn !== 2) begin errors++; $display("FAIL load%0d_stall_cycles: got %0d want 2", i, sn); end
            checks++; if (v !== 1'b1 || r !== exp[i]) begin errors++; $display("FAIL load%0d_rdata: got v=%b %h want v=1 %h", i, v, r, exp[i]); end
        end
`ifdef LSU_UNSIGNED_LOAD_EN
        run_load(4'd8, 32'h13, 1, 32'h80FF_0000, sn, rn, v, r);
        checks++; if (v !== 1'b1 || r !== 32'h0000_0080) begin errors++; $display("FAIL lbu_rdata: got v=%b %h want v=1 00000080", v, r); end
        run_load(4'd7, 32'h12, 1, 32'h80FF_0000, sn, rn, v, r);
        checks++; if (v !== 1'b1 || r !== 32'h0000_80FF) begin errors++; $display("FAIL lhu_rdata: got v=%b %h want v=1 000080FF", v, r); end
`else
        for (int op = 7; op <= 9; op++) begin
            req_valid = 1'b1; mem_op = 4'(op); addr = 32'h13;
            #1;
            checks++; if ({stall, exc_adel, exc_ades} !== 3'b000) begin errors++; $display("FAIL op%0d_ignored_comb: got %b want 000", op, {stall, exc_adel, exc_ades}); end
            tick();
            req_valid = 1'b0; mem_op = 4'd0;
            checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL op%0d_ignored_req: got %b want 0", op, m_req); end
        end
`endif
    endtask

    task automatic test_store();
        logic [3:0]  ops [4] = '{4'd5, 4'd6, 4'd4, 4'd4};
        logic [31:0] adr [4] = '{32'h22, 32'h21, 32'h7f20, 32'h7f04};
        logic [31:0] wd  [4] = '{32'h1234_ABCD, 32'h0000_005A, 32'hCAFE_F00D, 32'h0000_0001};
        logic [3:0]  ebe [4] = '{4'b1100, 4'b0010, 4'b1111, 4'b1111};
        logic [31:0] ewd [4] = '{32'hABCD_ABCD, 32'h5A5A_5A5A, 32'hCAFE_F00D, 32'h0000_0001};
        logic [31:0] ead [4] = '{32'h20, 32'h20, 32'h7f20, 32'h7f04};
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; mem_op = ops[i]; addr = adr[i]; wdata = wd[i];
            #1;
            checks++; if ({stall, exc_adel, exc_ades} !== 3'b100) begin errors++; $display("FAIL st%0d_accept: got %b want 100", i, {stall, exc_adel, exc_ades}); end
            tick();
            req_valid = 1'b0; mem_op = 4'd0; wdata = 32'hFFFF_FFFF;
            checks++; if (m_req !== 1'b1 || m_we !== 1'b1) begin errors++; $display("FAIL st%0d_req_we: got %b%b want 11", i, m_req, m_we); end
            checks++; if (m_byteen !== ebe[i]) begin errors++; $display("FAIL st%0d_byteen: got %b want %b", i, m_byteen, ebe[i]); end
            checks++; if (m_wdata !== ewd[i] || m_addr !== ead[i]) begin errors++; $display("FAIL st%0d_bus: got %h@%h want %h@%h", i, m_wdata, m_addr, ewd[i], ead[i]); end
            m_ack = 1'b1;
            tick();
            m_ack = 1'b0;
            checks++; if ({rdata_valid, stall, m_we} !== 3'b000) begin errors++; $display("FAIL st%0d_resp: got %b want 000", i, {rdata_valid, stall, m_we}); end
            tick();
        end
    endtask

    task automatic test_addr_errors();
        logic [3:0]  ops [9] = '{4'd2, 4'd4, 4'd1, 4'd1, 4'd5, 4'd1, 4'd1, 4'd1, 4'd6};
        logic [31:0] adr [9] = '{32'h7f00, 32'h7f08, 32'h3000, 32'h2, 32'h1, 32'h7f0c, 32'h10, 32'h7f24, 32'h7f13};
        logic        ov  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0]  exp [9] = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01};
        for (int i = 0; i < 9; i++) begin
            req_valid = 1'b1; mem_op = ops[i]; addr = adr[i]; exc_ov = ov[i];
            #1;
            checks++; if ({exc_adel, exc_ades, stall} !== {exp[i], 1'b0}) begin errors++; $display("FAIL adrerr%0d: got adel/ades/stall %b want %b", i, {exc_adel, exc_ades, stall}, {exp[i], 1'b0}); end
            tick();
            checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL adrerr%0d_no_req: got %b want 0", i, m_req); end
        end
        req_valid = 1'b1; mem_op = 4'd2; addr = 32'h7f00; exc_ov = 1'b0; flush = 1'b1;
        #1;
        checks++; if ({exc_adel, exc_ades, stall} !== 3'b000) begin errors++; $display("FAIL flush_idle_suppress: got %b want 000", {exc_adel, exc_ades, stall}); end
        mem_op = 4'd1; addr = 32'h10;
        tick();
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL flush_idle_no_accept: got %b want 0", m_req); end
        clear_inputs();
    endtask

    task automatic test_timeout(input logic [3:0] op, input logic is_store);
        int seen = 0;
        req_valid = 1'b1; mem_op = op; addr = 32'h40;
        tick();
        req_valid = 1'b0; mem_op = 4'd0;
        for (int c = 1; c <= 12; c++) begin
            if ((is_store ? exc_ades : exc_adel) === 1'b1) begin
                seen = c;
                break;
            end
            tick();
        end
        checks++; if (seen !== 5) begin errors++; $display("FAIL timeout_op%0d_cycle: got %0d want 5", op, seen); end
        checks++; if ({m_req, stall, is_store ? exc_adel : exc_ades} !== 3'b000) begin errors++; $display("FAIL timeout_op%0d_err_state: got %b want 000", op, {m_req, stall, is_store ? exc_adel : exc_ades}); end
        tick();
        checks++; if ({exc_adel, exc_ades} !== 2'b00) begin errors++; $display("FAIL timeout_op%0d_pulse: got %b want 00", op, {exc_adel, exc_ades}); end
    endtask

    task automatic test_flush();
        int sn, rn; logic v; logic [31:0] r;
        req_valid = 1'b1; mem_op = 4'd1; addr = 32'h10;
        tick();
        req_valid = 1'b0; mem_op = 4'd0;
        tick();
        flush = 1'b1; m_ack = 1'b1; m_rdata = 32'hDEAD_BEEF;
        tick();
        flush = 1'b0; m_ack = 1'b0;
        checks++; if ({m_req, rdata_valid, stall} !== 3'b000) begin errors++; $display("FAIL flush_req: got %b want 000", {m_req, rdata_valid, stall}); end
        tick();
        checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL flush_no_valid: got %b want 0", rdata_valid); end
        run_load(4'd1, 32'h14, 1, 32'h0BAD_F00D, sn, rn, v, r);
        checks++; if (sn !== 2 || r !== 32'h0BAD_F00D) begin errors++; $display("FAIL flush_then_idle: got %0d %h want 2 0badf00d", sn, r); end
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; mem_op = 4'd1; addr = 32'h24;
        tick();
        m_ack = 1'b1; m_rdata = 32'h1111_2222;
        tick();
        m_ack = 1'b0;
        #1;
        checks++; if ({rdata_valid, stall, m_req} !== 3'b100 || rdata !== 32'h1111_2222) begin errors++; $display("FAIL b2b_first: got %b %h want 100 11112222", {rdata_valid, stall, m_req}, rdata); end
        tick();
        addr = 32'h28;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: got %b want 1", stall); end
        tick();
        req_valid = 1'b0; mem_op = 4'd0;
        checks++; if (m_addr !== 32'h28) begin errors++; $display("FAIL b2b_second_addr: got %h want 28", m_addr); end
        m_ack = 1'b1; m_rdata = 32'h3333_4444;
        tick();
        m_ack = 1'b0;
        checks++; if (rdata_valid !== 1'b1 || rdata !== 32'h3333_4444) begin errors++; $display("FAIL b2b_second_rdata: got %b %h want 1 33334444", rdata_valid, rdata); end
        tick();
        // reset while in REQ aborts silently
        req_valid = 1'b1; mem_op = 4'd4; addr = 32'h30; wdata = 32'h5;
        tick();
        req_valid = 1'b0; mem_op = 4'd0; reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if ({m_req, stall, exc_adel, exc_ades} !== 4'b0000 || m_addr !== 32'h0) begin errors++; $display("FAIL reset_mid_access: got %b %h want 0000 0", {m_req, stall, exc_adel, exc_ades}, m_addr); end
        tick();
    endtask

    initial begin
        test_reset();
        test_lw();
        test_loads();
        test_store();
        test_addr_errors();
        test_timeout(4'd1, 1'b0);
        test_timeout(4'd4, 1'b1);
        test_flush();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
